inst_ram_ctrl: RTL and testbench

INST_RAM_CTRL -- requirements
Module: inst_ram_ctrl

---
 rtl/inst_ram_ctrl.sv | 153 +++++++++++++++
 tb/tb_inst_ram_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_ctrl.sv
// Instruction RAM controller: assembles a little-endian byte stream into 32-bit
// RAM writes and arbitrates the single read port between the IF stage and a monitor.
module inst_ram_ctrl #(
  parameter int IWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run_i,
  input  logic [IWIDTH-1:0] if_radr_i,
  input  logic              ld_start_i,
  input  logic [IWIDTH-1:0] ld_adr_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_err_o,
  output logic [IWIDTH:0]   ld_wcnt_o,
  input  logic              mon_req_i,
  input  logic [IWIDTH-1:0] mon_adr_i,
  output logic              mon_ack_o,
  output logic [31:0]       mon_rdata_o,
  output logic [IWIDTH-1:0] ram_radr_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [IWIDTH-1:0] ram_wadr_o,
  output logic [31:0]       ram_wdata_o,
  output logic              ram_wen_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  localparam logic [IWIDTH-1:0] ADR_ONE  = {{(IWIDTH-1){1'b0}}, 1'b1};
  localparam logic [IWIDTH:0]   WCNT_ONE = {{IWIDTH{1'b0}}, 1'b1};
  localparam logic [IWIDTH:0]   WCNT_MAX = {1'b1, {IWIDTH{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [IWIDTH-1:0] wptr_q, wptr_d;
  logic [23:0]       lanes_q, lanes_d;
  logic [IWIDTH:0]   wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [IWIDTH-1:0] wadr_q, wadr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wait_low_q, wait_low_d;

  // ld_start takes effect before a byte arriving in the same cycle
  logic [1:0]        bcnt_eff;
  logic [IWIDTH-1:0] wptr_eff;
  logic [IWIDTH:0]   wcnt_eff;
  logic              byte_acc;

  assign bcnt_eff = ld_start_i ? 2'd0 : bcnt_q;
  assign wptr_eff = ld_start_i ? ld_adr_i : wptr_q;
  assign wcnt_eff = ld_start_i ? '0 : wcnt_q;
  assign byte_acc = ld_valid_i & ~cpu_run_i;

  always_comb begin
    bcnt_d  = bcnt_eff;
    wptr_d  = wptr_eff;
    wcnt_d  = wcnt_eff;
    err_d   = ld_start_i ? 1'b0 : err_q;
    lanes_d = lanes_q;
    wen_d   = 1'b0;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    if (ld_valid_i && cpu_run_i) begin
      err_d = 1'b1;
    end
    if (byte_acc) begin
      bcnt_d = bcnt_eff + 2'd1;
      if (bcnt_eff == 2'd3) begin
        wen_d   = 1'b1;
        wadr_d  = wptr_eff;
        wdata_d = {ld_byte_i, lanes_q};
        wptr_d  = wptr_eff + ADR_ONE;
        if (wcnt_eff != WCNT_MAX) begin
          wcnt_d = wcnt_eff + WCNT_ONE;
        end
      end else begin
        lanes_d[{bcnt_eff, 3'b000} +: 8] = ld_byte_i;
      end
    end
  end

  // A pending word write wins the cycle; the read starts the cycle after.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    wait_low_d = wait_low_q & mon_req_i;
    case (state_q)
      S_IDLE: begin
        if (mon_req_i && !cpu_run_i && !wen_q && !wait_low_q) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = cpu_run_i ? S_IDLE : S_CAP;
      end
      S_CAP: begin
        state_d = S_IDLE;
        if (!cpu_run_i) begin
          rdata_d    = ram_rdata_i;
          ack_d      = 1'b1;
          wait_low_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bcnt_q     <= 2'd0;
      wptr_q     <= '0;
      lanes_q    <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      wadr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      wait_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      wptr_q     <= wptr_d;
      lanes_q    <= lanes_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      wen_q      <= wen_d;
      wadr_q     <= wadr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      wait_low_q <= wait_low_d;
    end
  end

  assign ram_radr_o  = (state_q == S_RD && !cpu_run_i) ? mon_adr_i : if_radr_i;
  assign ram_wen_o   = wen_q;
  assign ram_wadr_o  = wadr_q;
  assign ram_wdata_o = wdata_q;
  assign ld_err_o    = err_q;
  assign ld_wcnt_o   = wcnt_q;
  assign mon_ack_o   = ack_q;
  assign mon_rdata_o = rdata_q;

endmodule

// File: tb/tb_inst_ram_ctrl.sv
// Bench for inst_ram_ctrl: a byte-stream/word-memory reference model plus a
// behavioural 1R1W RAM, with directed cases followed by randomized loads and reads.
module tb_inst_ram_ctrl;
  localparam int IW    = 12;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_run;
  logic [IW-1:0] if_radr;
  logic          ld_start;
  logic [IW-1:0] ld_adr;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_err;
  logic [IW:0]   ld_wcnt;
  logic          mon_req;
  logic [IW-1:0] mon_adr;
  logic          mon_ack;
  logic [31:0]   mon_rdata;
  logic [IW-1:0] ram_radr;
  logic [31:0]   ram_rdata;
  logic [IW-1:0] ram_wadr;
  logic [31:0]   ram_wdata;
  logic          ram_wen;

  always #5 clk = ~clk;

  inst_ram_ctrl #(.IWIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_run_i(cpu_run), .if_radr_i(if_radr),
    .ld_start_i(ld_start), .ld_adr_i(ld_adr), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte),
    .ld_err_o(ld_err), .ld_wcnt_o(ld_wcnt), .mon_req_i(mon_req), .mon_adr_i(mon_adr),
    .mon_ack_o(mon_ack), .mon_rdata_o(mon_rdata), .ram_radr_o(ram_radr),
    .ram_rdata_i(ram_rdata), .ram_wadr_o(ram_wadr), .ram_wdata_o(ram_wdata),
    .ram_wen_o(ram_wen)
  );

  // Behavioural RAM: registered read, old data on same-address collision
  logic [31:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen) tb_mem[ram_wadr] <= ram_wdata;
    ram_rdata <= tb_mem[ram_radr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: words form from every 4 accepted bytes after a start
  typedef struct {
    logic [IW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] shadow [DEPTH];
  logic [7:0]  m_bytes[$];
  int          m_ptr;
  int          m_wcnt;
  bit          m_err;
  logic [31:0] last_mon_exp;

  function automatic void model_start(input int adr);
    m_ptr = adr;
    m_bytes.delete();
    m_wcnt = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_reset();
    model_start(0);
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit run);
    logic [31:0] w;
    if (run) begin
      m_err = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      exp_q.push_back('{a: IW'(m_ptr), d: w});
      shadow[m_ptr] = w;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_wcnt < DEPTH) m_wcnt++;
      m_bytes.delete();
    end
  endfunction

  // Write scoreboard
  wr_t           cur_wr;
  int            n_wr = 0;
  bit            quiet = 1'b0;
  logic [IW-1:0] last_wadr;
  logic [31:0]   last_wdata;

  always @(negedge clk) begin
    if (rst_n && ram_wen) begin
      n_wr++;
      last_wadr  = ram_wadr;
      last_wdata = ram_wdata;
      if (exp_q.size() == 0) begin
        check("wen_unexpected", 32'(ram_wen), 32'd0);
      end else begin
        cur_wr = exp_q.pop_front();
        check("wadr", 32'(ram_wadr), 32'(cur_wr.a));
        check("wdata", ram_wdata, cur_wr.d);
        if (!quiet) $display("write %03h <= %08h", ram_wadr, ram_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [IW-1:0] adr);
    ld_start = 1'b1;
    ld_adr   = adr;
    model_start(int'(adr));
    tick();
    ld_start = 1'b0;
  endtask

  task automatic do_start_byte(input logic [IW-1:0] adr, input logic [7:0] b);
    ld_start = 1'b1;
    ld_adr   = adr;
    ld_valid = 1'b1;
    ld_byte  = b;
    model_start(int'(adr));
    model_byte(b, 1'b0);
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit run);
    cpu_run  = run;
    ld_valid = 1'b1;
    ld_byte  = b;
    model_byte(b, run);
    tick();
    ld_valid = 1'b0;
    cpu_run  = 1'b0;
  endtask

  task automatic mon_read(input logic [IW-1:0] adr, input int exp_lat, input bit hold);
    int n;
    n = 0;
    mon_req = 1'b1;
    mon_adr = adr;
    while (n < 20) begin
      tick();
      n++;
      if (n == exp_lat - 2) check("rd_radr", 32'(ram_radr), 32'(adr));
      if (mon_ack) break;
    end
    check("mon_lat", 32'(n), 32'(exp_lat));
    check("mon_rdata", mon_rdata, shadow[adr]);
    last_mon_exp = shadow[adr];
    $display("read  %03h -> %08h after %0d cycles", adr, mon_rdata, n);
    if (hold) begin
      repeat (4) begin
        tick();
        check("no_reack", 32'(mon_ack), 32'd0);
      end
    end
    mon_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [IW-1:0] wa;
    logic [IW-1:0] ra;
    int            nb;
    int            base_wr;
    bit            acked;

    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 32'd0;
      shadow[i] = 32'd0;
    end
    rst_n = 1'b0; cpu_run = 1'b0; if_radr = 12'h5a5; ld_start = 1'b0; ld_adr = '0;
    ld_valid = 1'b0; ld_byte = '0; mon_req = 1'b0; mon_adr = '0;
    last_mon_exp = 32'd0; last_wadr = '0; last_wdata = '0;
    model_reset();
    idle(2);
    check("rst_err", 32'(ld_err), 32'd0);
    check("rst_wcnt", 32'(ld_wcnt), 32'd0);
    check("rst_ack", 32'(mon_ack), 32'd0);
    check("rst_rdata", mon_rdata, 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_wadr", 32'(ram_wadr), 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_radr", 32'(ram_radr), 32'h5a5);
    rst_n = 1'b1;
    idle(2);

    // Single word load
    do_start(12'h010);
    put_byte(8'h13, 1'b0); put_byte(8'h05, 1'b0); put_byte(8'h10, 1'b0); put_byte(8'h00, 1'b0);
    idle(3);
    check("w1_wadr", 32'(last_wadr), 32'h010);
    check("w1_wdata", last_wdata, 32'h00100513);
    check("w1_wcnt", 32'(ld_wcnt), 32'd1);

    // Monitor read; held request must not retrigger
    if_radr = 12'h123;
    mon_read(12'h010, 3, 1'b1);
    check("mon010", mon_rdata, 32'h00100513);

    // Back-to-back across the address wrap
    do_start(12'hfff);
    for (int i = 1; i <= 8; i++) put_byte(8'(i), 1'b0);
    idle(3);
    check("wrap_wadr", 32'(last_wadr), 32'h000);
    check("wrap_wdata", last_wdata, 32'h08070605);
    check("wrap_wcnt", 32'(ld_wcnt), 32'd2);

    // Run interlock drops a byte and sets the sticky error
    do_start(12'h200);
    put_byte(8'ha1, 1'b0); put_byte(8'hb2, 1'b0); put_byte(8'hc3, 1'b0);
    put_byte(8'hee, 1'b1);
    put_byte(8'hd4, 1'b0);
    idle(3);
    check("intlk_err", 32'(ld_err), 32'(m_err));
    check("intlk_err1", 32'(ld_err), 32'd1);
    check("intlk_wdata", last_wdata, 32'hd4c3b2a1);
    check("intlk_wcnt", 32'(ld_wcnt), 32'(m_wcnt));

    // Read raised while a word write is on the RAM port is deferred a cycle
    do_start(12'h300);
    check("start_clr_err", 32'(ld_err), 32'd0);
    wa = 12'h300;
    put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0); put_byte(8'h33, 1'b0); put_byte(8'h44, 1'b0);
    mon_read(wa, 4, 1'b0);

    // cpu_run pulse during RD aborts without ack, then the request retries
    mon_req = 1'b1;
    mon_adr = 12'h010;
    tick();
    if_radr = 12'h0ab;
    cpu_run = 1'b1;
    #1;
    check("abort_radr", 32'(ram_radr), 32'h0ab);
    tick();
    check("abort_ack0", 32'(mon_ack), 32'd0);
    tick();
    check("abort_ack1", 32'(mon_ack), 32'd0);
    check("abort_rdata", mon_rdata, last_mon_exp);
    cpu_run = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      tick();
      acked = mon_ack;
    end
    check("retry_ack", 32'(acked), 32'd1);
    check("retry_rdata", mon_rdata, shadow[12'h010]);
    last_mon_exp = shadow[12'h010];
    mon_req = 1'b0;
    tick();

    // Reset mid-word discards the partial word
    do_start(12'h400);
    put_byte(8'h99, 1'b0); put_byte(8'h88, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_wcnt", 32'(ld_wcnt), 32'd0);
    idle(2);
    rst_n = 1'b1;
    base_wr = n_wr;
    idle(2);
    put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b0); put_byte(8'h04, 1'b0);
    idle(3);
    check("post_rst_nwr", 32'(n_wr - base_wr), 32'd1);
    check("post_rst_wadr", 32'(last_wadr), 32'd0);
    check("post_rst_wdata", last_wdata, 32'h04030201);

    // Word counter saturates at the RAM depth
    do_start(IW'($urandom_range(0, DEPTH - 1)));
    quiet = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 4; i++) put_byte(8'($urandom), 1'b0);
    idle(3);
    quiet = 1'b0;
    check("sat_wcnt", 32'(ld_wcnt), 32'(DEPTH));

    // Randomized loads with interlock hits, gaps and start+byte collisions
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) do_start_byte(IW'($urandom), 8'($urandom));
      else do_start(IW'($urandom));
      nb = $urandom_range(0, 14);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        put_byte(8'($urandom), $urandom_range(0, 5) == 0);
      end
      idle(3);
      check("rnd_wcnt", 32'(ld_wcnt), 32'(m_wcnt));
      check("rnd_err", 32'(ld_err), 32'(m_err));
      if_radr = IW'($urandom);
      #1;
      check("rnd_radr", 32'(ram_radr), 32'(if_radr));
      for (int r = 0; r < 2; r++) begin
        ra = (r == 0 && m_wcnt > 0) ? IW'((m_ptr + DEPTH - 1) % DEPTH) : IW'($urandom);
        mon_read(ra, 3, 1'b0);
      end
    end

    check("wq_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
